// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin sharing of one SPI Master among three requesters
module spi_txn_scheduler #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int TIMEOUT       = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  REQ,
  input  logic [1:0]  MODE0,
  input  logic [1:0]  MODE1,
  input  logic [1:0]  MODE2,
  input  logic [7:0]  WDATA0,
  input  logic [7:0]  WDATA1,
  input  logic [7:0]  WDATA2,
  output logic [2:0]  ACK,
  output logic        ERR,
  output logic [7:0]  RDATA,
  output logic        M_READ_MEMORY,
  output logic        M_START,
  output logic [7:0]  M_DATA,
  output logic        M_CPOL,
  output logic        M_CPHA,
  output logic [0:2]  M_SS,
  input  logic        M_SS1,
  input  logic        M_SS2,
  input  logic        M_SS3,
  input  logic [7:0]  M_SHIFT
);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TO  = TW'(TIMEOUT);
  localparam logic [TW-1:0] SU  = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] SB  = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] ONE = TW'(1);
  typedef enum logic [3:0] {
    S_SYNC, S_IDLE, S_SETUP1, S_LOAD, S_SETUP2, S_START,
    S_WAIT_BUSY, S_WAIT_DONE, S_GUARD, S_CAPTURE, S_ACK, S_SYNC_ACK
  } state_t;
  state_t state, state_n;
  logic [TW-1:0] cnt;
  logic [1:0] last, idx, p1, p2, gnt;
  logic [2:0] ss_m, ss_s;
  logic busy_s, timeout;
  logic [7:0] g_data;
  logic [1:0] g_mode;
  assign busy_s  = ~&ss_s;
  assign timeout = cnt == TO;
  // round-robin pick: last+1, then last+2, then last itself
  always_comb begin
    p1     = last == 2'd2 ? 2'd0 : last + 2'd1;
    p2     = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    gnt    = REQ[p1] ? p1 : REQ[p2] ? p2 : last;
    g_data = gnt == 2'd0 ? WDATA0 : gnt == 2'd1 ? WDATA1 : WDATA2;
    g_mode = gnt == 2'd0 ? MODE0 : gnt == 2'd1 ? MODE1 : MODE2;
  end
  // next-state sequencing of one Master transfer
  always_comb begin
    state_n = state;
    case (state)
      S_SYNC:      state_n = (!busy_s && cnt == ONE) ? S_IDLE : S_SYNC;
      S_IDLE:      state_n = |REQ ? S_SETUP1 : S_IDLE;
      S_SETUP1:    state_n = cnt == SU ? S_LOAD : S_SETUP1;
      S_LOAD:      state_n = cnt == SB ? S_SETUP2 : S_LOAD;
      S_SETUP2:    state_n = cnt == SU ? S_START : S_SETUP2;
      S_START:     state_n = cnt == SB ? S_WAIT_BUSY : S_START;
      S_WAIT_BUSY: state_n = busy_s ? S_WAIT_DONE : timeout ? S_SYNC_ACK : S_WAIT_BUSY;
      S_WAIT_DONE: state_n = !busy_s ? S_GUARD : timeout ? S_SYNC_ACK : S_WAIT_DONE;
      S_GUARD:     state_n = cnt == ONE ? S_CAPTURE : S_GUARD;
      S_CAPTURE:   state_n = S_ACK;
      S_ACK:       state_n = S_IDLE;
      S_SYNC_ACK:  state_n = S_SYNC;
      default:     state_n = S_SYNC;
    endcase
  end
  // slave-select synchronizers, reset as busy so SYNC only trusts a freshly sampled idle
  always_ff @(posedge CLK or posedge RST)
    if (RST) {ss_s, ss_m} <= '0;
    else     {ss_s, ss_m} <= {ss_m, M_SS1, M_SS2, M_SS3};
  // state register and phase counter; counter restarts on state change and on activity during SYNC
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= S_SYNC;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || (state == S_SYNC && busy_s)) ? '0 : cnt + 1'b1;
    end
  // grant: latch requester, its configuration and slave code, advance the pointer
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      last   <= 2'd2;
      idx    <= 2'd0;
      M_DATA <= 8'h00;
      M_CPOL <= 1'b0;
      M_CPHA <= 1'b0;
      M_SS   <= 3'b111;
    end else if (state == S_IDLE && |REQ) begin
      last             <= gnt;
      idx              <= gnt;
      M_DATA           <= g_data;
      {M_CPOL, M_CPHA} <= g_mode;
      M_SS             <= gnt == 2'd0 ? 3'b011 : gnt == 2'd1 ? 3'b101 : 3'b110;
    end
  // strobes and completion pulse decoded from next state so they come straight off flops
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      M_READ_MEMORY <= 1'b0;
      M_START       <= 1'b0;
      ACK           <= 3'b000;
    end else begin
      M_READ_MEMORY <= state_n == S_LOAD;
      M_START       <= state_n == S_START;
      ACK           <= (state_n == S_ACK || state_n == S_SYNC_ACK) ? 3'b001 << idx : 3'b000;
    end
  // result: captured byte on completion, zero with error on timeout abort
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      RDATA <= 8'h00;
      ERR   <= 1'b0;
    end else if (state == S_CAPTURE) begin
      RDATA <= M_SHIFT;
      ERR   <= 1'b0;
    end else if (state_n == S_SYNC_ACK) begin
      RDATA <= 8'h00;
      ERR   <= 1'b1;
    end
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// tb_spi_txn_scheduler: scoreboard bench with a behavioural SPI Master model
module tb_spi_txn_scheduler;
  logic CLK = 1'b0, RST = 1'b1;
  logic [2:0] REQ = 3'b000;
  logic [1:0] MODE0 = 2'b00, MODE1 = 2'b00, MODE2 = 2'b00;
  logic [7:0] WDATA0 = 8'h00, WDATA1 = 8'h00, WDATA2 = 8'h00;
  logic [2:0] ACK;
  logic ERR;
  logic [7:0] RDATA;
  logic M_READ_MEMORY, M_START;
  logic [7:0] M_DATA;
  logic M_CPOL, M_CPHA;
  logic [0:2] M_SS;
  logic M_SS1 = 1'b1, M_SS2 = 1'b1, M_SS3 = 1'b1;
  logic [7:0] M_SHIFT = 8'h00;

  spi_txn_scheduler dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .MODE0(MODE0), .MODE1(MODE1), .MODE2(MODE2),
    .WDATA0(WDATA0), .WDATA1(WDATA1), .WDATA2(WDATA2),
    .ACK(ACK), .ERR(ERR), .RDATA(RDATA),
    .M_READ_MEMORY(M_READ_MEMORY), .M_START(M_START),
    .M_DATA(M_DATA), .M_CPOL(M_CPOL), .M_CPHA(M_CPHA), .M_SS(M_SS),
    .M_SS1(M_SS1), .M_SS2(M_SS2), .M_SS3(M_SS3), .M_SHIFT(M_SHIFT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] idx;
    logic [1:0] mode;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0, rm_rises = 0, st_rises = 0, rel_cyc = 0;
  logic master_en = 1'b1, mbusy = 1'b0;
  logic [7:0] miso_byte = 8'h00;

  always @(posedge CLK) cyc++;
  always @(posedge M_READ_MEMORY) rm_rises++;
  always @(posedge M_START) st_rises++;

  // Master model: loads M_DATA, drops the selected SS line, shifts in miso_byte MSB first
  initial begin
    logic [0:2] sel;
    logic [7:0] mb;
    forever begin
      @(posedge M_START);
      #1;
      if (master_en) begin
        if (exp_q.size() != 0) begin
          tests++;
          if (M_SS !== ~(3'b100 >> exp_q[0].idx) || M_DATA !== exp_q[0].wdata || {M_CPOL, M_CPHA} !== exp_q[0].mode) begin
            fails++;
            $display("FAIL start_config: got SS=%b DATA=%h MODE=%b%b, want SS=%b DATA=%h MODE=%b",
                     M_SS, M_DATA, M_CPOL, M_CPHA, ~(3'b100 >> exp_q[0].idx), exp_q[0].wdata, exp_q[0].mode);
          end
        end
        sel = M_SS;
        mb = miso_byte;
        mbusy = 1'b1;
        M_SHIFT = M_DATA;
        repeat (2) @(negedge CLK);
        {M_SS1, M_SS2, M_SS3} = sel;
        for (int b = 7; b >= 0; b--) begin
          repeat (4) @(negedge CLK);
          M_SHIFT = {M_SHIFT[6:0], mb[b]};
        end
        repeat (2) @(negedge CLK);
        {M_SS1, M_SS2, M_SS3} = 3'b111;
        rel_cyc = cyc;
        mbusy = 1'b0;
      end
    end
  end

  // scoreboard: every ACK pulse is matched against the oldest expected transaction
  always @(negedge CLK) begin
    if (!RST && ACK !== 3'b000) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: got ACK=%b, want none", ACK);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ACK !== (3'b001 << e.idx) || ERR !== e.err || RDATA !== e.rdata) begin
          fails++;
          $display("FAIL ack_result: got ACK=%b ERR=%b RDATA=%h, want ACK=%b ERR=%b RDATA=%h",
                   ACK, ERR, RDATA, 3'b001 << e.idx, e.err, e.rdata);
        end
        if (!e.err) begin
          tests++;
          if (rm_rises !== 1 || st_rises !== 1) begin
            fails++;
            $display("FAIL strobe_edges: got READ_MEMORY=%0d START=%0d rises, want 1 and 1", rm_rises, st_rises);
          end
        end
      end
      rm_rises = 0;
      st_rises = 0;
    end
  end

  task automatic push(input logic [1:0] i, input logic [1:0] m, input logic [7:0] w, input logic [7:0] r, input logic e);
    exp_q.push_back('{i, m, w, r, e});
  endtask

  task automatic wait_acks(input int n, input int budget, output int got);
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge CLK);
      if (ACK !== 3'b000) got++;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    REQ = 3'b000;
    repeat (3) @(negedge CLK);
    tests++;
    if (ACK !== 3'b000 || ERR !== 1'b0 || RDATA !== 8'h00) begin
      fails++;
      $display("FAIL reset_result: got ACK=%b ERR=%b RDATA=%h, want 000 0 00", ACK, ERR, RDATA);
    end
    tests++;
    if (M_READ_MEMORY !== 1'b0 || M_START !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes: got RM=%b START=%b, want 0 0", M_READ_MEMORY, M_START);
    end
    tests++;
    if (M_DATA !== 8'h00 || M_CPOL !== 1'b0 || M_CPHA !== 1'b0 || M_SS !== 3'b111) begin
      fails++;
      $display("FAIL reset_config: got DATA=%h CPOL=%b CPHA=%b SS=%b, want 00 0 0 111", M_DATA, M_CPOL, M_CPHA, M_SS);
    end
    RST = 1'b0;
  endtask

  task automatic test_basic;
    int n, got;
    MODE0 = 2'b00;
    WDATA0 = 8'hA5;
    miso_byte = 8'hFF;
    push(2'd0, 2'b00, 8'hA5, 8'hFF, 1'b0);
    REQ = 3'b001;
    n = 0;
    while (M_SS === 3'b111 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (M_SS !== 3'b011) begin
      fails++;
      $display("FAIL basic_grant: got SS=%b, want 011", M_SS);
    end
    n = 0;
    while (M_START !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (n !== 6) begin
      fails++;
      $display("FAIL grant_to_start: got %0d cycles, want 6", n);
    end
    wait_acks(1, 300, got);
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    tests++;
    if (got !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL basic_ack: got %0d acks, %0d pending, want 1 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_round_robin;
    int got;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    MODE0 = 2'b00; MODE1 = 2'b01; MODE2 = 2'b11;
    WDATA0 = 8'h11; WDATA1 = 8'h22; WDATA2 = 8'h33;
    miso_byte = 8'h3C;
    push(2'd0, 2'b00, 8'h11, 8'h3C, 1'b0);
    push(2'd1, 2'b01, 8'h22, 8'h3C, 1'b0);
    push(2'd2, 2'b11, 8'h33, 8'h3C, 1'b0);
    push(2'd0, 2'b00, 8'h11, 8'h3C, 1'b0);
    REQ = 3'b111;
    wait_acks(4, 2000, got);
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    tests++;
    if (got !== 4 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL round_robin: got %0d acks, %0d pending, want 4 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_fairness;
    int got;
    MODE0 = 2'b10; MODE1 = 2'b01; MODE2 = 2'b11;
    WDATA0 = 8'h81; WDATA1 = 8'h42; WDATA2 = 8'h24;
    miso_byte = 8'hE7;
    push(2'd1, 2'b01, 8'h42, 8'hE7, 1'b0);
    push(2'd0, 2'b10, 8'h81, 8'hE7, 1'b0);
    REQ = 3'b011;
    wait_acks(2, 1000, got);
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    tests++;
    if (got !== 2 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL fair_no_req2: got %0d acks, %0d pending, want 2 and 0", got, exp_q.size());
    end
    push(2'd1, 2'b01, 8'h42, 8'hE7, 1'b0);
    push(2'd2, 2'b11, 8'h24, 8'hE7, 1'b0);
    REQ = 3'b111;
    wait_acks(2, 1000, got);
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    tests++;
    if (got !== 2 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL fair_req2: got %0d acks, %0d pending, want 2 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_mode_sweep;
    int got;
    logic [7:0] pat [4];
    pat = '{8'h55, 8'hAA, 8'h69, 8'hC3};
    for (int m = 0; m < 4; m++) begin
      MODE2 = 2'(m);
      WDATA2 = 8'hF0 + 8'(m);
      miso_byte = pat[m];
      push(2'd2, 2'(m), 8'hF0 + 8'(m), pat[m], 1'b0);
      REQ = 3'b100;
      wait_acks(1, 300, got);
      REQ = 3'b000;
      MODE2 = ~MODE2;
      repeat (2) @(negedge CLK);
      tests++;
      if (got !== 1 || exp_q.size() !== 0) begin
        fails++;
        $display("FAIL mode_sweep[%0d]: got %0d acks, %0d pending, want 1 and 0", m, got, exp_q.size());
      end
    end
  endtask

  task automatic test_timeout;
    int got;
    master_en = 1'b0;
    MODE0 = 2'b01;
    WDATA0 = 8'h77;
    push(2'd0, 2'b01, 8'h77, 8'h00, 1'b1);
    REQ = 3'b001;
    wait_acks(1, 3000, got);
    REQ = 3'b000;
    master_en = 1'b1;
    repeat (2) @(negedge CLK);
    tests++;
    if (got !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL timeout_ack: got %0d acks, %0d pending, want 1 and 0", got, exp_q.size());
    end
    MODE1 = 2'b11;
    WDATA1 = 8'h5E;
    miso_byte = 8'hB4;
    push(2'd1, 2'b11, 8'h5E, 8'hB4, 1'b0);
    REQ = 3'b010;
    wait_acks(1, 300, got);
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    tests++;
    if (got !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL after_timeout: got %0d acks, %0d pending, want 1 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int n, got;
    MODE0 = 2'b11;
    WDATA0 = 8'hC3;
    miso_byte = 8'h96;
    push(2'd0, 2'b11, 8'hC3, 8'h96, 1'b0);
    REQ = 3'b001;
    n = 0;
    while (M_START !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    REQ = 3'b000;
    #1;
    tests++;
    if (M_START !== 1'b0 || M_READ_MEMORY !== 1'b0 || M_SS !== 3'b111 || M_DATA !== 8'h00 ||
        ACK !== 3'b000 || ERR !== 1'b0 || RDATA !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset_outputs: got START=%b RM=%b SS=%b DATA=%h ACK=%b ERR=%b RDATA=%h, want 0 0 111 00 000 0 00",
               M_START, M_READ_MEMORY, M_SS, M_DATA, ACK, ERR, RDATA);
    end
    exp_q.delete();
    rm_rises = 0;
    st_rises = 0;
    @(negedge CLK);
    RST = 1'b0;
    MODE1 = 2'b10;
    WDATA1 = 8'hE1;
    miso_byte = 8'h4B;
    push(2'd1, 2'b10, 8'hE1, 8'h4B, 1'b0);
    REQ = 3'b010;
    n = 0;
    while (M_SS === 3'b111 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (M_SS !== 3'b101 || mbusy !== 1'b0 || cyc < rel_cyc + 2) begin
      fails++;
      $display("FAIL mid_reset_hold: got SS=%b master_busy=%b gap=%0d, want 101 0 >=2", M_SS, mbusy, cyc - rel_cyc);
    end
    wait_acks(1, 300, got);
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    tests++;
    if (got !== 1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL mid_reset_ack: got %0d acks, %0d pending, want 1 and 0", got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_fairness();
    test_mode_sweep();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
